// File: rtl/alu_pipe.sv
// Registered, handshaked ALU with signed compare, variable shifts and an
// iterative shift-add unsigned multiply behind a one-entry output register.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             cOut,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SGTU = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_MULL = 4'd10;
  localparam logic [3:0] OP_MULH = 4'd11;

  logic [0:0]         state;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_hi;

  logic in_xfer, out_xfer, is_mul, mul_last;

  assign inReady  = (state == S_IDLE) && (!outValid || outReady);
  assign busy     = (state == S_MUL);
  assign in_xfer  = inValid && inReady;
  assign out_xfer = outValid && outReady;
  assign is_mul   = (opcode == OP_MULL) || (opcode == OP_MULH);
  assign mul_last = (state == S_MUL) && (cnt == SHW'(WIDTH - 1));

  // Extended-width helpers: the extra bit carries the add/sub carry or the
  // last bit shifted out of a shift.
  logic [SHW-1:0]      amt;
  logic [WIDTH:0]      sum_ext, diff_ext, shl_ext, srl_ext, sra_ext;
  logic signed [WIDTH:0] sra_src;

  assign amt      = b[SHW-1:0];
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign shl_ext  = {1'b0, a} << amt;
  assign srl_ext  = {a, 1'b0} >> amt;
  assign sra_src  = {a, 1'b0};
  assign sra_ext  = sra_src >>> amt;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SGTU: alu_res = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SRL: begin
        alu_res = srl_ext[WIDTH:1];
        alu_c   = srl_ext[0];
      end
      OP_SRA: begin
        alu_res = sra_ext[WIDTH:1];
        alu_c   = sra_ext[0];
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: ;
    endcase
  end

  // Right-shifting shift-add: each step adds a (if the current multiplier
  // bit is set) into the high half, then shifts the whole product right.
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_c;

  assign step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mul_b[0] ? mul_a : '0)};
  assign acc_next = {step_sum, acc[WIDTH-1:1]};
  assign mul_res  = mul_hi ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
  assign mul_c    = |acc_next[2*WIDTH-1:WIDTH];

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      mul_hi <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_xfer && is_mul) begin
            mul_a  <= a;
            mul_b  <= b;
            mul_hi <= opcode[0];
            acc    <= '0;
            cnt    <= '0;
            state  <= S_MUL;
          end
        end
        default: begin
          acc   <= acc_next;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + SHW'(1);
          if (mul_last) state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      outValid <= 1'b0;
      result   <= '0;
      cOut     <= 1'b0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
    end else if (in_xfer && !is_mul) begin
      outValid <= 1'b1;
      result   <= alu_res;
      cOut     <= alu_c;
      zero     <= (alu_res == '0);
      ovf      <= alu_v;
    end else if (mul_last) begin
      outValid <= 1'b1;
      result   <= mul_res;
      cOut     <= mul_c;
      zero     <= (mul_res == '0);
      ovf      <= 1'b0;
    end else if (out_xfer) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors with literal expectations plus an
// arithmetic reference model checked on every output transfer.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid, inReady, outValid, outReady;
  logic [3:0]  opcode;
  logic [15:0] a, b, result;
  logic        cOut, zero, ovf, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        v;
  } exp_t;

  exp_t exp_q[$];

  alu_pipe dut (
    .clk(clk), .rstN(rstN),
    .inValid(inValid), .inReady(inReady), .opcode(opcode), .a(a), .b(b),
    .outValid(outValid), .outReady(outReady), .result(result),
    .cOut(cOut), .zero(zero), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model built from plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    longint ux, uy, sx, sy, full, p;
    int     n;
    exp_t   e;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    n  = int'(y & 16'h000F);
    e  = '0;
    case (op)
      4'd0: begin
        full  = ux + uy;
        e.res = 16'(full);
        e.c   = (full >= 65536);
        e.v   = (sx + sy > 32767) || (sx + sy < -32768);
      end
      4'd1: begin
        e.res = 16'(ux - uy);
        e.c   = (ux >= uy);
        e.v   = (sx - sy > 32767) || (sx - sy < -32768);
      end
      4'd2: e.res = x & y;
      4'd3: e.res = x | y;
      4'd4: e.res = x ^ y;
      4'd5: e.res = (ux > uy) ? 16'd1 : 16'd0;
      4'd6: begin
        full  = ux << n;
        e.res = 16'(full);
        e.c   = (n != 0) && (((full >> 16) & 1) == 1);
      end
      4'd7: begin
        e.res = 16'(ux >> n);
        e.c   = (n != 0) && (((ux >> (n - 1)) & 1) == 1);
      end
      4'd8: begin
        e.res = 16'(sx >>> n);
        e.c   = (n != 0) && (((ux >> (n - 1)) & 1) == 1);
      end
      4'd9: e.res = (sx < sy) ? 16'd1 : 16'd0;
      4'd10, 4'd11: begin
        p     = ux * uy;
        e.res = (op == 4'd11) ? 16'(p >> 16) : 16'(p);
        e.c   = ((p >> 16) != 0);
      end
      default: e.res = 16'd0;
    endcase
    e.z = (e.res == 16'd0);
    return e;
  endfunction

  // Compare process: sample between edges; pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rstN) begin
      exp_q.delete();
    end else begin
      if (outValid && outReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("model_out", {13'd0, result, cOut, zero, ovf}, {13'd0, e.res, e.c, e.z, e.v});
        end
      end
      if (inValid && inReady) exp_q.push_back(model(opcode, a, b));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    int n;
    n = 0;
    opcode  = op;
    a       = x;
    b       = y;
    inValid = 1'b1;
    @(negedge clk);
    while (!inReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [15:0] r, input logic c,
                            input logic z, input logic v);
    check(name, {12'd0, outValid, result, cOut, zero, ovf}, {12'd0, 1'b1, r, c, z, v});
  endtask

  task automatic wait_mul_done(input string name, input logic [15:0] r, input logic c);
    for (int i = 0; i < 16; i++) begin
      check({name, "_busy"}, {29'd0, busy, inReady, outValid}, {29'd0, 3'b100});
      @(posedge clk);
      #1;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    expect_out(name, r, c, (r == 16'd0), 1'b0);
  endtask

  logic [15:0] vec_a [4] = '{16'h8001, 16'h00F0, 16'h8000, 16'h1234};
  logic [15:0] vec_b [4] = '{16'h0001, 16'h0F0F, 16'h8000, 16'h0000};

  initial begin
    rstN = 1'b0; inValid = 1'b0; outReady = 1'b1;
    opcode = '0; a = '0; b = '0;
    #3;
    check("reset_state", {25'd0, outValid, busy, cOut, zero, ovf, inReady, |result},
          {25'd0, 7'b0000010});
    #17 rstN = 1'b1;
    @(posedge clk); #1;

    issue(4'd0, 16'h7FFF, 16'h0001); expect_out("add_ovf", 16'h8000, 1'b0, 1'b0, 1'b1);
    issue(4'd1, 16'h0003, 16'h0005); expect_out("sub_borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0);
    issue(4'd1, 16'h0005, 16'h0005); expect_out("sub_equal", 16'h0000, 1'b1, 1'b1, 1'b0);
    issue(4'd8, 16'h8001, 16'h0003); expect_out("sra", 16'hF000, 1'b0, 1'b0, 1'b0);
    issue(4'd7, 16'h8001, 16'h0003); expect_out("srl", 16'h1000, 1'b0, 1'b0, 1'b0);
    issue(4'd6, 16'h8001, 16'h0003); expect_out("shl", 16'h0008, 1'b0, 1'b0, 1'b0);
    issue(4'd6, 16'h8001, 16'h0010); expect_out("shl_amt0", 16'h8001, 1'b0, 1'b0, 1'b0);
    issue(4'd6, 16'h8001, 16'h0001); expect_out("shl_carry", 16'h0002, 1'b1, 1'b0, 1'b0);
    issue(4'd7, 16'h8001, 16'h0001); expect_out("srl_carry", 16'h4000, 1'b1, 1'b0, 1'b0);
    issue(4'd9, 16'hFFFF, 16'h0001); expect_out("slt_neg", 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(4'd5, 16'hFFFF, 16'h0001); expect_out("sgtu", 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(4'd9, 16'h0001, 16'hFFFF); expect_out("slt_pos", 16'h0000, 1'b0, 1'b1, 1'b0);
    issue(4'd13, 16'hFFFF, 16'hFFFF); expect_out("illegal", 16'h0000, 1'b0, 1'b1, 1'b0);

    issue(4'd10, 16'h1234, 16'h0010); wait_mul_done("mul_lo", 16'h2340, 1'b1);
    issue(4'd11, 16'h1234, 16'h0010); wait_mul_done("mul_hi", 16'h0001, 1'b1);
    issue(4'd11, 16'hFFFF, 16'hFFFF); wait_mul_done("mul_hi_max", 16'hFFFE, 1'b1);

    // Sweep every opcode over a few operand pairs; the model checks each.
    for (int op = 0; op < 16; op++)
      for (int k = 0; k < 4; k++)
        issue(4'(op), vec_a[k], vec_b[k]);

    // Backpressure: drain, stall one result, present a second add.
    @(posedge clk); #1;
    outReady = 1'b0;
    issue(4'd0, 16'h0001, 16'h0002);
    opcode = 4'd0; a = 16'h0005; b = 16'h0006; inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {14'd0, outValid, inReady, result}, {14'd0, 1'b1, 1'b0, 16'h0003});
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    #1 check("ready_comb", {31'd0, inReady}, 32'd1);
    @(posedge clk); #1;
    expect_out("both_xfer", 16'h000B, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream of 8 adds, one accept per cycle.
    for (int i = 0; i < 8; i++) begin
      a = 16'(i * 16'h0100); b = 16'(i + 1); inValid = 1'b1;
      check("stream_ready", {31'd0, inReady}, 32'd1);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    expect_out("stream_last", 16'h0708, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of a multiply.
    issue(4'd10, 16'h1234, 16'h0010);
    repeat (7) @(posedge clk);
    #1 rstN = 1'b0;
    #1 check("reset_mid_mul", {26'd0, outValid, busy, cOut, zero, ovf, |result}, 32'd0);
    @(negedge clk); #2 rstN = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      check("no_stale", {30'd0, outValid, busy}, 32'd0);
      @(posedge clk); #1;
    end
    issue(4'd0, 16'h1111, 16'h2222); expect_out("post_reset_add", 16'h3333, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 16-bit combinational ALU in the execute stage. It registers its result and adds signed compare, variable shifts (logical and arithmetic), and an iterative unsigned multiply. Operands enter through a valid/ready interface. Results, with carry/zero/overflow flags, are held in a one-entry output register until the consumer accepts them. The block sits between the ID/EX pipeline register and EX/MEM; a multiply stalls upstream through `inReady`.

## Interface
- `WIDTH`, default 16: datapath width. Power of two, ≥ 4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; never overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstN`  in  1  reset, asynchronous, active-low.
- `inValid`  in  1  operands and opcode presented.
- `inReady`  out  1  block can accept; a transfer occurs on an edge where `inValid && inReady`.
- `opcode`  in  4  operation select.
- `a`, `b`  in  WIDTH each  operands.
- `outValid`  out  1  `result` and flags valid.
- `outReady`  in  1  consumer accepts; an output transfer occurs on an edge where `outValid && outReady`.
- `result`  out  WIDTH  registered result.
- `cOut`, `zero`, `ovf`  out  1 each  registered flags.
- `busy`  out  1  multiply in progress.

## Operation
- Opcodes (unsigned unless stated):
  - 0: add.
  - 1: sub, computed as a + ~b + 1.
  - 2: and. 3: or. 4: xor.
  - 5: a > b, unsigned.
  - 6: a << b[SHW-1:0]. 7: logical right shift. 8: arithmetic right shift.
  - 9: a < b, signed.
  - 10: low half of a*b. 11: high half of a*b.
  - 12–15: illegal; result 0, all flags 0 except `zero`=1.
- Compare results are zero-extended to 0 or 1.
- Flags:
  - `zero` = (result == 0) for every opcode.
  - Add: `cOut` = carry out of bit WIDTH-1.
  - Sub: `cOut` = carry out as well, which is 1 when a ≥ b unsigned (no borrow).
  - `ovf` = signed overflow for add/sub only, otherwise 0.
  - Shifts: `cOut` = last bit shifted out, or 0 when the amount is 0. Upper bits of `b` beyond SHW are ignored.
  - Mul (10/11): `cOut` = 1 when the high half is non-zero; `ovf` = 0.
  - All other opcodes: `cOut` = 0.
- FSM states:
  - IDLE: `inReady = !outValid || outReady`. On a transfer of opcode 10/11, latch a, b and opcode, clear the 2·WIDTH accumulator and counter, and go to MUL. Any other opcode writes result and flags directly.
  - MUL: `busy`=1, `inReady`=0. One shift-add step per cycle over WIDTH cycles (counter 0..WIDTH-1). After the last step, write result/flags, set `outValid`, and return to IDLE.
- Output register:
  - Once set, `outValid`, `result` and flags hold unchanged until an output transfer.
  - If an output transfer and a single-cycle input transfer occur on the same edge, the new result is loaded and `outValid` stays 1 (full throughput).
  - An output transfer alone clears `outValid`; `result` keeps its last value.
- Boundaries:
  - `inValid` while in MUL: ignored, no transfer.
  - `outReady` high while `outValid`=0: no effect.
  - Multiply finishing while the previous result is still unconsumed cannot happen, because IDLE admits an input only when the output slot frees on that edge.
- Reset (`rstN` low, async):
  - State goes to IDLE; counter and accumulator clear.
  - `outValid`, `result`, `cOut`, `zero`, `ovf` and `busy` all go to 0.
  - A multiply in progress is abandoned; no result is produced.
  - `inReady` reads 1 during reset but no transfer is taken. The first transfer is possible on the first edge after `rstN` rises.

## Timing
- Single-cycle ops: accepted on edge N; `outValid` and `result` are visible after edge N, i.e. latency 1. Throughput is 1 per cycle while `outReady`=1.
- Multiply: accepted on edge N; steps run on edges N+1..N+WIDTH; `outValid` is visible after edge N+WIDTH. Latency is WIDTH cycles (16 at default). `inReady` is low for the WIDTH cycles following edge N.
- `inReady` depends combinationally on `outReady`. No other combinational input-to-output paths exist.

## Test plan
- Add 0x7FFF + 0x0001 → result 0x8000, `ovf`=1, `cOut`=0, `zero`=0, `outValid` one cycle after accept. Sub 0x0003 − 0x0005 → 0xFFFE, `cOut`=0, `ovf`=0.
- Shifts with a=0x8001, b=0x0003:
  - sra → 0xF000, `cOut`=0.
  - srl → 0x1000.
  - shl → 0x0008, `cOut`=0.
  - b=0x0010 (amount 0) → result 0x8001, `cOut`=0.
- Signed compare: op 9 with a=0xFFFF, b=0x0001 → 1. Op 5 with the same operands → 1. Op 9 with a=0x0001, b=0xFFFF → 0.
- Multiply:
  - 0x1234 × 0x0010, op 10 → 0x2340, `cOut`=1, `outValid` exactly 16 cycles after accept, `busy` high throughout, `inReady` low.
  - Op 11 with the same operands → 0x0001.
  - 0xFFFF × 0xFFFF, op 11 → 0xFFFE.
- Backpressure: issue add with `outReady`=0 for 5 cycles → `result` stable, `inReady`=0, a second `inValid` not taken. Raising `outReady` lets both transfers happen on one edge. A back-to-back stream of 8 adds then completes in 8 cycles.
- Reset mid-multiply: drop `rstN` at step 7 → all outputs 0 immediately. After release no stale result appears; a fresh add completes with latency 1.
